dw_layer_scheduler: RTL and testbench
=====================================

Name: dw_layer_scheduler

Overview:
- Sequences the 4-lane depthwise compute datapath across one full layer.
- Walks output pixels in raster order; for each pixel, issues channel groups of CHANNEL_PARALLELISM one per cycle.
- Tracks pipeline latency to flag result write-back, and hands each finished pixel to the pointwise stage via a ready/done handshake.
- Sits between the layer controller (start/config) and the window buffer, weight ROM and intermediate buffer.

Parameters:
- DATA_WIDTH, 8, feature/weight element width (passed through to the package; no datapath here)
- CHANNEL_PARALLELISM, 4, channels processed per issue cycle
- PIPE_LAT, 3, cycles from issue to result available at the bias/quant stage
- MAX_CH, 64, maximum supported channel count (sizes the internal counters)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches config and begins the layer
- layer  in  4  layer index; latched, drives bias_base
- output_size  in  8  output map height = width
- channel  in  8  channel count for this layer
- win_ready  in  1  window buffer holds a valid 3x3 window for the current pixel
- pt_ready  in  1  pointwise stage can accept a finished pixel
- win_req  out  1  one-cycle pulse requesting the window for (out_h, out_w)
- out_h, out_w  out  8 each  current output pixel coordinates
- issue  out  1  valid for engine inputs this cycle
- ch_sel  out  8  base channel of the group being issued
- lane_mask  out  CHANNEL_PARALLELISM  active lanes in the issued group
- res_valid  out  1  issue delayed by PIPE_LAT cycles
- res_ch  out  8  ch_sel delayed by PIPE_LAT cycles
- res_mask  out  CHANNEL_PARALLELISM  lane_mask delayed by PIPE_LAT cycles
- bias_base  out  8  0 if layer<4; 3 if layer<8; else 35
- pixel_done  out  1  pulse when the last group of a pixel retires
- layer_done  out  1  pulse when the last pixel is accepted by pointwise
- busy  out  1  high from start until layer_done

Behaviour:
- Reset: all outputs 0; FSM in IDLE; delay line cleared.
- FSM states and transitions:
  - IDLE: on start, latch config and go to REQ. start is ignored outside IDLE.
  - REQ: pulse win_req, go to WAIT_WIN.
  - WAIT_WIN: when win_ready, go to ISSUE.
  - ISSUE: issue=1 every cycle; ch_sel steps 0, CP, 2CP, ...; leaves after group G-1, where G = ceil(channel/CP).
  - DRAIN: count PIPE_LAT cycles until the last res_valid, then pulse pixel_done and go to HANDOFF.
  - HANDOFF: wait for pt_ready. On the accepting cycle, advance the pixel: out_w+1; when out_w = output_size-1, wrap to 0 and increment out_h. Return to REQ. If this was the last pixel (output_size-1, output_size-1), pulse layer_done and go to IDLE.
- Channel masking: lane_mask bit i = (ch_sel+i < channel). Partial groups are allowed, e.g. channel=3 gives mask 0111 and G=1.
- The delay line is a shift register of depth PIPE_LAT carrying issue, ch_sel and lane_mask. It is independent of the FSM, so results keep retiring during HANDOFF stalls.
- Degenerate config: channel=0 or output_size=0 gives a layer_done pulse the cycle after start, with no issue.
- pt_ready held high: back-to-back pixels; REQ follows the accept cycle.
- Reset mid-layer: immediate return to IDLE; the delay line flushes; no done pulses.
- Throughput per pixel: 1 (REQ) + window wait + G + PIPE_LAT + handoff wait.

Optional Feature:
- DW_SCHED_PERF_EN:
  - Defined: adds a 32-bit output stall_cycles, counting cycles spent in WAIT_WIN or HANDOFF with the condition false. It clears on start and saturates at all-ones.
  - Undefined: the port and counter are absent.

Decomposition:
- Package dw_sched_pkg holds:
  - state enum
  - CP default
  - bias base constants 0/3/35 and layer thresholds 4/8
  - ceil-div function for the group count
- One natural sub-module: dw_sched_delay_line (parameterised width/depth shift register for res_valid/res_ch/res_mask).

Test Plan:
- channel=3, output_size=2, win_ready and pt_ready tied 1 → four pixels; each has one issue with lane_mask=0111; res_valid arrives 3 cycles after issue; layer_done after pixel (1,1).
- channel=32, output_size=1 → ch_sel issued as 0,4,...,28 on 8 consecutive cycles; pixel_done 3 cycles after ch_sel=28; bias_base follows layer: 5→3, 9→35.
- channel=6 → group masks 1111 then 0011; res_mask matches with 3-cycle lag.
- pt_ready held 0 for 10 cycles after pixel_done → no win_req during the stall; out_w advances only on the accept cycle; with DW_SCHED_PERF_EN, stall_cycles=10.
- output_size=3 → pixels visited in raster order; out_w wraps 2→0 as out_h increments; exactly 9 pixel_done pulses and 1 layer_done.
- rst_n asserted during ISSUE at ch_sel=8 → all outputs 0 immediately; no res_valid afterwards; a new start runs cleanly from (0,0).

Source files
------------

// File: rtl/dw_sched_pkg.sv
// Shared types and constants for the depthwise layer scheduler.
//   - state_e   : scheduler FSM states
//   - CpDefault : default channel parallelism (lanes per issue cycle)
//   - bias base constants and the layer thresholds that select them
//   - ceil_div  : group-count helper, bias_of : layer -> bias base
package dw_sched_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned CpDefault = 4;

  localparam logic [7:0] BiasBase0 = 8'd0;
  localparam logic [7:0] BiasBase1 = 8'd3;
  localparam logic [7:0] BiasBase2 = 8'd35;
  localparam logic [3:0] LayerThr1 = 4'd4;
  localparam logic [3:0] LayerThr2 = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitWin,
    StIssue,
    StDrain,
    StHandoff
  } state_e;

  // den must be non-zero; 9-bit operands keep num + den - 1 from wrapping.
  function automatic logic [8:0] ceil_div(input logic [8:0] num, input logic [8:0] den);
    return (num + den - 9'd1) / den;
  endfunction

  function automatic logic [7:0] bias_of(input logic [3:0] layer);
    if (layer < LayerThr1) return BiasBase0;
    if (layer < LayerThr2) return BiasBase1;
    return BiasBase2;
  endfunction

endpackage

// File: rtl/dw_layer_scheduler_if.sv
// Handshake/bus bundle of the depthwise layer scheduler.
//   master : scheduler side (consumes config and ready flags, drives everything else)
//   slave  : environment side (layer controller, window buffer, engine, pointwise stage)
// Signals: start/layer/output_size/channel (config), win_req/win_ready (window),
// issue/ch_sel/lane_mask (engine), res_valid/res_ch/res_mask (write-back),
// pixel_done/pt_ready (pointwise), layer_done/busy/bias_base (status).
// With DW_SCHED_PERF_EN defined, stall_cycles is added.
interface dw_layer_scheduler_if
  import dw_sched_pkg::*;
#(
  parameter int unsigned CP = CpDefault
);
  logic          start;
  logic [3:0]    layer;
  logic [7:0]    output_size;
  logic [7:0]    channel;
  logic          win_ready;
  logic          pt_ready;
  logic          win_req;
  logic [7:0]    out_h;
  logic [7:0]    out_w;
  logic          issue;
  logic [7:0]    ch_sel;
  logic [CP-1:0] lane_mask;
  logic          res_valid;
  logic [7:0]    res_ch;
  logic [CP-1:0] res_mask;
  logic [7:0]    bias_base;
  logic          pixel_done;
  logic          layer_done;
  logic          busy;
`ifdef DW_SCHED_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  modport master (
    input  start, layer, output_size, channel, win_ready, pt_ready,
    output win_req, out_h, out_w, issue, ch_sel, lane_mask, res_valid, res_ch, res_mask,
    output bias_base, pixel_done, layer_done, busy
`ifdef DW_SCHED_PERF_EN
    , output stall_cycles
`endif
  );

  modport slave (
    output start, layer, output_size, channel, win_ready, pt_ready,
    input  win_req, out_h, out_w, issue, ch_sel, lane_mask, res_valid, res_ch, res_mask,
    input  bias_base, pixel_done, layer_done, busy
`ifdef DW_SCHED_PERF_EN
    , input stall_cycles
`endif
  );

endinterface

// File: rtl/dw_sched_delay_line.sv
// Fixed-depth shift register; models the compute pipeline latency so the
// write-back strobes line up with the engine results.
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes all stages)
//   d_i           : word entering the pipeline this cycle
//   q_o           : word that entered Depth cycles ago
module dw_sched_delay_line #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/dw_layer_scheduler.sv
// Depthwise layer scheduler: walks output pixels in raster order, issues channel
// groups of CHANNEL_PARALLELISM one per cycle, retires them through a PIPE_LAT
// delay line and hands each finished pixel to the pointwise stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dw_layer_scheduler_if.master (config, window, engine, result, status)
// Optional: DW_SCHED_PERF_EN adds bus.stall_cycles, a saturating count of cycles
// spent waiting in WAIT_WIN or HANDOFF, cleared on start.
// PIPE_LAT must be at least 2; channel counts above MAX_CH are not supported.
module dw_layer_scheduler
  import dw_sched_pkg::*;
#(
  parameter int unsigned CHANNEL_PARALLELISM = CpDefault,
  parameter int unsigned PIPE_LAT            = 3,
  parameter int unsigned MAX_CH              = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  dw_layer_scheduler_if.master bus
);

  localparam int unsigned Cp     = CHANNEL_PARALLELISM;
  localparam int unsigned GrpW   = $clog2(MAX_CH / Cp) + 1;
  localparam int unsigned DrainW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned ResW   = 1 + 8 + Cp;

  state_e            state_q;
  logic [7:0]        size_q, chan_q, out_h_q, out_w_q, ch_sel_q, bias_q;
  logic [GrpW-1:0]   grp_q, num_grp_q;
  logic [DrainW-1:0] drain_q;
  logic [Cp-1:0]     mask_q;
  logic              win_req_q, issue_q, pixel_done_q, layer_done_q, busy_q;
  logic [ResW-1:0]   res_q;

  // Lane i is live when its channel index is still below the channel count.
  function automatic logic [Cp-1:0] mask_of(input logic [8:0] base, input logic [7:0] chan);
    logic [Cp-1:0] m;
    m = '0;
    for (int i = 0; i < Cp; i++) m[i] = (base + 9'(i)) < {1'b0, chan};
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      size_q       <= '0;
      chan_q       <= '0;
      out_h_q      <= '0;
      out_w_q      <= '0;
      ch_sel_q     <= '0;
      bias_q       <= '0;
      grp_q        <= '0;
      num_grp_q    <= '0;
      drain_q      <= '0;
      mask_q       <= '0;
      win_req_q    <= 1'b0;
      issue_q      <= 1'b0;
      pixel_done_q <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      win_req_q    <= 1'b0;
      pixel_done_q <= 1'b0;
      layer_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            size_q    <= bus.output_size;
            chan_q    <= bus.channel;
            bias_q    <= bias_of(bus.layer);
            num_grp_q <= GrpW'(ceil_div({1'b0, bus.channel}, 9'(Cp)));
            out_h_q   <= '0;
            out_w_q   <= '0;
            if (bus.channel == 8'd0 || bus.output_size == 8'd0) begin
              layer_done_q <= 1'b1;  // empty layer: finish without issuing
            end else begin
              busy_q    <= 1'b1;
              win_req_q <= 1'b1;
              state_q   <= StReq;
            end
          end
        end
        StReq: state_q <= StWaitWin;
        StWaitWin: begin
          if (bus.win_ready) begin
            issue_q  <= 1'b1;
            ch_sel_q <= '0;
            grp_q    <= '0;
            mask_q   <= mask_of(9'd0, chan_q);
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (grp_q == num_grp_q - 1'b1) begin
            issue_q  <= 1'b0;
            ch_sel_q <= '0;
            mask_q   <= '0;
            drain_q  <= '0;
            state_q  <= StDrain;
          end else begin
            grp_q    <= grp_q + 1'b1;
            ch_sel_q <= ch_sel_q + 8'(Cp);
            mask_q   <= mask_of({1'b0, ch_sel_q} + 9'(Cp), chan_q);
          end
        end
        StDrain: begin
          // One drain cycle is already spent leaving ISSUE; pixel_done then
          // lands on the same cycle as the last res_valid.
          if (drain_q == DrainW'(PIPE_LAT - 2)) begin
            pixel_done_q <= 1'b1;
            state_q      <= StHandoff;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StHandoff: begin
          if (bus.pt_ready) begin
            if (out_w_q == size_q - 8'd1) begin
              out_w_q <= '0;
              if (out_h_q == size_q - 8'd1) begin
                out_h_q      <= '0;
                layer_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= StIdle;
              end else begin
                out_h_q   <= out_h_q + 8'd1;
                win_req_q <= 1'b1;
                state_q   <= StReq;
              end
            end else begin
              out_w_q   <= out_w_q + 8'd1;
              win_req_q <= 1'b1;
              state_q   <= StReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Runs independently of the FSM so results keep retiring during stalls.
  dw_sched_delay_line #(
    .Width(ResW),
    .Depth(PIPE_LAT)
  ) u_delay_line (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   ({issue_q, ch_sel_q, mask_q}),
    .q_o   (res_q)
  );

  assign {bus.res_valid, bus.res_ch, bus.res_mask} = res_q;

  assign bus.win_req    = win_req_q;
  assign bus.out_h      = out_h_q;
  assign bus.out_w      = out_w_q;
  assign bus.issue      = issue_q;
  assign bus.ch_sel     = ch_sel_q;
  assign bus.lane_mask  = mask_q;
  assign bus.bias_base  = bias_q;
  assign bus.pixel_done = pixel_done_q;
  assign bus.layer_done = layer_done_q;
  assign bus.busy       = busy_q;

`ifdef DW_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic        stall_now;

  assign stall_now = (state_q == StWaitWin && !bus.win_ready) ||
                     (state_q == StHandoff && !bus.pt_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == StIdle && bus.start) begin
      stall_q <= '0;
    end else if (stall_now && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dw_layer_scheduler.sv
// Self-checking bench for dw_layer_scheduler: a table of layer configurations
// with hand-computed totals, a per-cycle monitor for issue order, masks, the
// 3-cycle write-back lag and raster order, plus stall and mid-layer reset runs.
module tb_dw_layer_scheduler;

  localparam int unsigned Cp = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dw_layer_scheduler_if #(.CP(Cp)) bus ();

  dw_layer_scheduler #(
    .CHANNEL_PARALLELISM(Cp),
    .PIPE_LAT(3),
    .MAX_CH(64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] layer;
    int sz;
    int ch;
    int exp_t;      // cycles from start cycle to layer_done cycle
    int exp_iss;
    int exp_pd;
    int exp_lanes;
    int exp_bias;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_fail = 0;

  int cfg_ch = 0, cfg_g = 1, cfg_sz = 1;
  int grp_exp = 0, ph = 0, pw = 0;
  int cnt_issue = 0, cnt_pd = 0, cnt_ld = 0, cnt_lanes = 0;
  logic [12:0] dl [3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor with its own expected issue sequence and delay model.
  always @(negedge clk) begin : mon
    logic [3:0]  em;
    logic [12:0] cur;
    if (!rst_n) begin
      grp_exp = 0;
      ph = 0;
      pw = 0;
      for (int i = 0; i < 3; i++) dl[i] = '0;
    end else begin
      check("res_valid", int'(bus.res_valid), int'(dl[2][12]));
      check("res_ch", int'(bus.res_ch), int'(dl[2][11:4]));
      check("res_mask", int'(bus.res_mask), int'(dl[2][3:0]));
      cur = '0;
      if (bus.issue) begin
        for (int i = 0; i < Cp; i++) em[i] = (grp_exp * int'(Cp) + i) < cfg_ch;
        check("ch_sel", int'(bus.ch_sel), grp_exp * int'(Cp));
        check("lane_mask", int'(bus.lane_mask), int'(em));
        cur = {1'b1, 8'(grp_exp * int'(Cp)), em};
        cnt_issue++;
        cnt_lanes += $countones(bus.lane_mask);
        grp_exp++;
        if (grp_exp >= cfg_g) grp_exp = 0;
      end
      if (bus.win_req) begin
        check("win_req_out_h", int'(bus.out_h), ph);
        check("win_req_out_w", int'(bus.out_w), pw);
        pw++;
        if (pw == cfg_sz) begin
          pw = 0;
          ph++;
        end
      end
      if (bus.pixel_done) cnt_pd++;
      if (bus.layer_done) cnt_ld++;
      dl[2] = dl[1];
      dl[1] = dl[0];
      dl[0] = cur;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_win_req"}, int'(bus.win_req), 0);
    check({tag, "_issue"}, int'(bus.issue), 0);
    check({tag, "_ch_sel"}, int'(bus.ch_sel), 0);
    check({tag, "_lane_mask"}, int'(bus.lane_mask), 0);
    check({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check({tag, "_res_ch"}, int'(bus.res_ch), 0);
    check({tag, "_res_mask"}, int'(bus.res_mask), 0);
    check({tag, "_pixel_done"}, int'(bus.pixel_done), 0);
    check({tag, "_layer_done"}, int'(bus.layer_done), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_out_h"}, int'(bus.out_h), 0);
    check({tag, "_out_w"}, int'(bus.out_w), 0);
    check({tag, "_bias_base"}, int'(bus.bias_base), 0);
  endtask

  // Called at a negedge; start is high for exactly that cycle.
  task automatic start_layer(input logic [3:0] l, input int sz, input int ch);
    bus.layer       = l;
    bus.output_size = 8'(sz);
    bus.channel     = 8'(ch);
    cfg_sz = (sz == 0) ? 1 : sz;
    cfg_ch = ch;
    cfg_g  = (ch + int'(Cp) - 1) / int'(Cp);
    if (cfg_g == 0) cfg_g = 1;
    grp_exp = 0;
    ph = 0;
    pw = 0;
    cnt_issue = 0;
    cnt_pd = 0;
    cnt_ld = 0;
    cnt_lanes = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_layer_done(input int budget, output int t);
    bit seen;
    seen = 1'b0;
    t = 0;
    while (t < budget && !seen) begin
      @(negedge clk);
      t++;
      if (bus.layer_done) seen = 1'b1;
    end
    if (!seen) t = -1;
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    start_layer(v.layer, v.sz, v.ch);
    @(negedge clk);
    check("bias_base", int'(bus.bias_base), v.exp_bias);
    check("busy_after_start", int'(bus.busy), (v.sz > 0 && v.ch > 0) ? 1 : 0);
    t = 1;
    if (!bus.layer_done) begin
      wait_layer_done(3000, t);
      if (t >= 0) t = t + 1;
    end
    check("layer_done_time", t, v.exp_t);
    @(negedge clk);
    check("layer_done_pulse", int'(bus.layer_done), 0);
    check("busy_idle", int'(bus.busy), 0);
    check("issue_count", cnt_issue, v.exp_iss);
    check("pixel_done_count", cnt_pd, v.exp_pd);
    check("lane_total", cnt_lanes, v.exp_lanes);
    check("layer_done_count", cnt_ld, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int bad;
    bit seen;
    vec_t rv;

    // T = N*(G+5)+1 with N = size^2, G = ceil(channel/4); empty layer T = 1.
    vecs[0] = '{4'd0,  2, 3,  25, 4,  4, 12, 0};
    vecs[1] = '{4'd5,  1, 32, 14, 8,  1, 32, 3};
    vecs[2] = '{4'd9,  1, 6,  8,  2,  1, 6,  35};
    vecs[3] = '{4'd3,  3, 4,  55, 9,  9, 36, 0};
    vecs[4] = '{4'd8,  2, 0,  1,  0,  0, 0,  35};
    vecs[5] = '{4'd7,  0, 8,  1,  0,  0, 0,  3};
    vecs[6] = '{4'd15, 1, 64, 22, 16, 1, 64, 35};
    vecs[7] = '{4'd4,  2, 5,  29, 8,  4, 20, 3};

    bus.start = 1'b0;
    bus.layer = '0;
    bus.output_size = '0;
    bus.channel = '0;
    bus.win_ready = 1'b1;
    bus.pt_ready = 1'b1;

    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Pointwise stall: 10 cycles with pt_ready low from the pixel_done cycle.
    bus.pt_ready = 1'b0;
    start_layer(4'd0, 2, 6);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.pixel_done) seen = 1'b1;
    end
    check("stall_pixel_done_seen", int'(seen), 1);
    for (int k = 0; k < 10; k++) begin
      check("stall_win_req", int'(bus.win_req), 0);
      check("stall_out_w", int'(bus.out_w), 0);
      if (k == 3) begin
        bus.layer = 4'd12;
        bus.start = 1'b1;  // must be ignored outside IDLE
      end
      if (k == 4) bus.start = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("stall_end_win_req", int'(bus.win_req), 0);
    bus.pt_ready = 1'b1;
    @(negedge clk);
    check("accept_win_req", int'(bus.win_req), 1);
    check("accept_out_w", int'(bus.out_w), 1);
    check("accept_out_h", int'(bus.out_h), 0);
    check("stall_bias_kept", int'(bus.bias_base), 0);
`ifdef DW_SCHED_PERF_EN
    check("stall_cycles", int'(bus.stall_cycles), 10);
`endif
    wait_layer_done(500, t);
    check("stall_layer_done_seen", (t >= 0) ? 1 : 0, 1);
    @(negedge clk);
    check("stall_pixel_done_count", cnt_pd, 4);
    check("stall_layer_done_count", cnt_ld, 1);

    // Reset in the middle of ISSUE at ch_sel = 8.
    start_layer(4'd2, 2, 32);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.issue && bus.ch_sel == 8'd8) seen = 1'b1;
    end
    check("rst_ch_sel8_seen", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.res_valid || bus.pixel_done || bus.layer_done || bus.issue || bus.win_req) bad++;
    end
    check("post_reset_quiet", bad, 0);
    rv = '{4'd6, 1, 8, 8, 2, 1, 8, 3};
    run_vec(rv);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
